spi_master_ctrl: RTL

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl_pkg.sv | 20 ++
 rtl/spi_sclk_gen.sv | 62 ++++++
 rtl/spi_master_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/spi_master_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl_pkg
// Shared definitions for the SPI master blocks: controller state encoding and
// the SPI mode constants (mode 0: CPOL=0, CPHA=0).
// ---------------------------------------------------------------------------
package spi_master_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  // SCLK idle level and data phase (mode 0)
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_sclk_gen.sv
// ---------------------------------------------------------------------------
// spi_sclk_gen
// Divides the system clock into SCLK half-periods of CLK_DIV cycles.
//   clk, rst : system clock, asynchronous active-high reset
//   en       : run the divider (held at 0 and SCLK parked idle when low)
//   toggle   : allow SCLK to change at the end of the current half-period
//   sclk     : registered SPI clock
//   tick     : last cycle of the current half-period
//   rise     : this cycle's edge moves SCLK from idle to active level
//   fall     : this cycle's edge moves SCLK from active back to idle level
// ---------------------------------------------------------------------------
module spi_sclk_gen
  import spi_master_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic toggle,
  output logic sclk,
  output logic tick,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;

  always_comb begin
    tick = en && (cnt_q == CNT_MAX);
    rise = tick && toggle && (sclk_q == CPOL);
    fall = tick && toggle && (sclk_q != CPOL);

    // Counter restarts at every phase boundary so each phase is exactly
    // CLK_DIV cycles regardless of CLK_DIV being a power of two.
    if (!en || tick) cnt_d = '0;
    else             cnt_d = cnt_q + 1'b1;

    if (!en)              sclk_d = CPOL;
    else if (rise || fall) sclk_d = ~sclk_q;
    else                  sclk_d = sclk_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above and ordering never matters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= CPOL;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl
// Single-byte SPI master, mode 0, MSB first.
//   CLK, RST : system clock, asynchronous active-high reset
//   START    : transfer request (only looked at in IDLE)
//   TX_DATA  : byte to send, captured when START is accepted
//   MISO     : serial data from slave
//   SCLK     : SPI clock (idle low)
//   MOSI     : serial data to slave
//   CS_N     : slave select, active low
//   RX_DATA  : last complete received byte
//   BUSY     : high from first SETUP cycle through last HOLD cycle
//   DONE     : one-cycle pulse in the cycle RX_DATA is updated
// Sequence: IDLE -> SETUP (CLK_DIV) -> XFER (16*CLK_DIV) -> HOLD (CLK_DIV)
//           -> FIN (1) -> IDLE.
// ---------------------------------------------------------------------------
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [7:0] TX_DATA,
  input  logic       MISO,
  output logic       SCLK,
  output logic       MOSI,
  output logic       CS_N,
  output logic [7:0] RX_DATA,
  output logic       BUSY,
  output logic       DONE
);

  state_e     state_q, state_d;
  logic [6:0] tx_sh_q, tx_sh_d;     // bits still to send after the one on MOSI
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [2:0] bit_cnt_q, bit_cnt_d; // falling SCLK edges seen, wraps on the 8th
  logic       mosi_q, mosi_d;
  logic       cs_n_q, cs_n_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic gen_en, gen_toggle;
  logic sclk, tick, rise, fall;
  logic sample_stb, shift_stb;
  logic last_low;

  // After the 8th falling edge the counter is back at 0 while SCLK is low;
  // that low half completes the 8th period and then XFER ends.
  assign last_low   = (sclk == CPOL) && (bit_cnt_q == 3'd0);
  assign gen_en     = (state_q == ST_SETUP) || (state_q == ST_XFER) || (state_q == ST_HOLD);
  assign gen_toggle = (state_q == ST_SETUP) || ((state_q == ST_XFER) && !last_low);

  // Mode 0: capture on the leading edge, advance data on the trailing edge.
  assign sample_stb = (CPHA == 1'b0) ? rise : fall;
  assign shift_stb  = (CPHA == 1'b0) ? fall : rise;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk    (CLK),
    .rst    (RST),
    .en     (gen_en),
    .toggle (gen_toggle),
    .sclk   (sclk),
    .tick   (tick),
    .rise   (rise),
    .fall   (fall)
  );

  always_comb begin
    // NOTE: every _d gets a default before the case, so no path leaves a
    // variable unassigned and no latch is inferred.
    state_d   = state_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d   = ST_SETUP;
          mosi_d    = TX_DATA[7];
          tx_sh_d   = TX_DATA[6:0];
          bit_cnt_d = 3'd0;
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
        end
      end
      ST_SETUP: if (tick) state_d = ST_XFER;
      ST_XFER:  if (tick && last_low) state_d = ST_HOLD;
      ST_HOLD: begin
        if (tick) begin
          state_d   = ST_FIN;
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          mosi_d    = 1'b0;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (sample_stb) rx_sh_d = {rx_sh_q[6:0], MISO};

    if (shift_stb) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      // No next bit after the 8th edge: MOSI keeps bit 0 through HOLD.
      if (bit_cnt_q != 3'd7) begin
        mosi_d  = tx_sh_q[6];
        tx_sh_d = {tx_sh_q[5:0], 1'b0};
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign SCLK    = sclk;
  assign MOSI    = mosi_q;
  assign CS_N    = cs_n_q;
  assign RX_DATA = rx_data_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

endmodule
